ttl_bus_share_ctrl: RTL
=======================

Name: ttl_bus_share_ctrl

Overview:
- Sequencer and arbiter that shares one 8-bit board bus between NUM_REQ octal edge-triggered latch/driver stages in the System86 TTL model.
- For the winning requester it issues a one-cycle capture strobe to that stage's latch clock, then a timed active-low output enable.
- A bus-idle turnaround follows each ownership so that two drivers never overlap.
- Sits between the CPU/video timing logic (requesters) and the bank of latch stages feeding the shared bus.

Parameters:
- NUM_REQ, 4, number of requesting latch stages (2..8).
- HOLD_CYCLES, 2, cycles nOE is held low per grant (1..15).
- TURNAROUND, 1, all-disabled cycles after each drive (0..3).

Ports:
- CLK  input  1  system clock, all state changes on rising edge.
- nRST  input  1  asynchronous active-low reset.
- REQ  input  NUM_REQ  per-stage request, level-sensitive, sampled on CLK.
- LATCH  output  NUM_REQ  one-hot capture strobe, high for one cycle.
- nOE  output  NUM_REQ  per-stage output enable, active-low, at most one low.
- GNT  output  NUM_REQ  one-hot grant, high from LATCH cycle through last DRIVE cycle.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse on the last DRIVE cycle.

Behaviour:
- Interface: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset while nRST=0:
  - LATCH=0, GNT=0, nOE=all 1, BUSY=0, DONE=0.
  - State=IDLE, round-robin pointer=0, counters=0.
  - Takes effect immediately, including mid-grant. The bus is released in the same instant.
- All outputs are registered. There is no combinational path from REQ to any output.
- IDLE:
  - On an edge with any REQ high, pick a winner and go to LATCH.
  - Winner is the first set bit searching upward from pointer, wrapping at NUM_REQ-1 to 0.
- LATCH (1 cycle):
  - LATCH[w]=1, GNT[w]=1, nOE all 1.
  - Next state is DRIVE. The pointer is loaded with (w+1) mod NUM_REQ.
- DRIVE (HOLD_CYCLES cycles):
  - nOE[w]=0, GNT[w]=1, LATCH=0. DONE=1 on the final cycle only.
  - The grant is committed: deasserting REQ[w] does not shorten DRIVE.
  - Next state is TURN if TURNAROUND>0. Otherwise arbitration happens directly, as in TURN exit.
- TURN (TURNAROUND cycles):
  - nOE all 1, GNT=0.
  - On exit, if any REQ is high, go to LATCH with a new winner (no IDLE cycle). Otherwise go to IDLE.
- Latency:
  - From REQ first sampled high in IDLE: LATCH strobe in the next cycle, nOE low the cycle after.
  - Back-to-back grant period is 1+HOLD_CYCLES+TURNAROUND cycles.
- Fairness: a continuously requesting stage waits at most NUM_REQ-1 grants.
- Simultaneous requests: resolved only by the pointer, never by fixed index.
- A REQ arriving during LATCH/DRIVE/TURN is not lost. It is sampled at the next arbitration point.
- Invariants:
  - popcount(~nOE)≤1 and popcount(LATCH)≤1.
  - nOE[i]=0 implies GNT[i]=1.
  - LATCH and a low nOE are never active in the same cycle.
- Counters are sized for the maximum parameter values. Terminal count is compared against the parameter minus 1.

Test Plan:
- Reset then single request: REQ=0100 held → LATCH=0100 for 1 cycle; nOE=1011 for 2 cycles with DONE on the 2nd; 1 TURN cycle with nOE=1111; then the next grant again goes to stage 2.
- Simultaneous requests: REQ=1111 from reset → grant order 0,1,2,3,0; each period is 4 cycles; no IDLE cycles between grants.
- Early drop: REQ[1] pulsed for one cycle → full LATCH + 2 DRIVE cycles still occur; then the block returns to IDLE with BUSY=0.
- Async reset mid-DRIVE: nRST low between edges → nOE=1111 and GNT=0 immediately; after release with REQ=0010, grant goes to stage 1 with pointer back at 0.
- Parameter sweep: HOLD_CYCLES=1, TURNAROUND=0, REQ=0011 → alternating grants with period 2. The assertion checker confirms one-hot nOE and no LATCH/nOE overlap across 10k random REQ cycles.

Source files
------------

// File: rtl/ttl_bus_share_ctrl.sv
// Round-robin sequencer sharing one 8-bit board bus between latch/driver stages.
// Each grant is a one-cycle capture strobe, a timed active-low output enable, then an idle turnaround.
`timescale 1ns/1ps

module ttl_bus_share_ctrl #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned TURNAROUND  = 1
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [NUM_REQ-1:0] REQ,
   output logic [NUM_REQ-1:0] LATCH,
   output logic [NUM_REQ-1:0] nOE,
   output logic [NUM_REQ-1:0] GNT,
   output logic               BUSY,
   output logic               DONE
);

   // Index and counter widths cover the largest legal NUM_REQ (8) and HOLD_CYCLES (15).
   localparam int unsigned    PTR_W     = 3;
   localparam int unsigned    CNT_W     = 4;
   localparam int unsigned    REQ_PAD_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_DRIVE = 2'd2,
      ST_TURN  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   win_q, win_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] latch_q, latch_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] noe_q, noe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [REQ_PAD_W-1:0] req_pad;
   logic                 any_req;
   logic [PTR_W-1:0]     arb_win;
   logic                 arb_found;
   logic [CNT_W-1:0]     arb_sum;
   logic [PTR_W-1:0]     arb_idx;
   state_e               arb_state;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

   assign req_pad = REQ_PAD_W'(REQ);
   assign any_req = |REQ;

   // Round-robin search: first set request at or above the pointer, wrapping at NUM_REQ-1.
   always_comb begin
      arb_win   = '0;
      arb_found = 1'b0;
      arb_sum   = '0;
      arb_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         arb_sum = CNT_W'(ptr_q) + CNT_W'(k);
         if (arb_sum >= CNT_W'(NUM_REQ)) begin
            arb_sum = arb_sum - CNT_W'(NUM_REQ);
         end
         arb_idx = arb_sum[PTR_W-1:0];
         if (!arb_found && req_pad[arb_idx]) begin
            arb_found = 1'b1;
            arb_win   = arb_idx;
         end
      end
      arb_state = any_req ? ST_LATCH : ST_IDLE;
   end

   // Next-state logic; outputs are derived from the next state so they can be registered.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      latch_d = '0;
      gnt_d   = '0;
      noe_d   = '1;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_LATCH;
               win_d   = arb_win;
            end
         end
         ST_LATCH: begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            ptr_d   = (win_q == LAST_IDX) ? '0 : (win_q + PTR_W'(1));
         end
         ST_DRIVE: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               if (TURNAROUND > 0) begin
                  state_d = ST_TURN;
               end else begin
                  state_d = arb_state;
                  if (any_req) win_d = arb_win;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_TURN: begin
            if (cnt_q == TURN_LAST) begin
               cnt_d   = '0;
               state_d = arb_state;
               if (any_req) win_d = arb_win;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (state_d == ST_LATCH) begin
         latch_d = onehot(win_d);
         gnt_d   = onehot(win_d);
      end
      if (state_d == ST_DRIVE) begin
         gnt_d  = onehot(win_d);
         noe_d  = ~onehot(win_d);
         done_d = (cnt_d == HOLD_LAST);
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset releases the bus immediately.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         latch_q <= '0;
         gnt_q   <= '0;
         noe_q   <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         latch_q <= latch_d;
         gnt_q   <= gnt_d;
         noe_q   <= noe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign LATCH = latch_q;
   assign GNT   = gnt_q;
   assign nOE   = noe_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;

endmodule
